irq_stim_gen: RTL and testbench

- Parametrised, synthesizable interrupt stimulus generator and halt monitor for core-level simulation and FPGA bring-up.
- Drives NUM_CH interrupt lines into the core while the program sequencer reports idle. Each channel waits a pseudo-random delay taken from an internal LFSR.
- Watches the program-memory opcode bus for the halt opcode, then raises a sticky done flag after a programmable drain delay.
- Replaces ad-hoc random interrupt injection with deterministic, seedable, multi-channel stimulus.

---
 rtl/irq_stim_gen.sv | 170 +++++++++++++++++
 tb/tb_irq_stim_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_stim_gen.sv
// Seedable multi-channel interrupt stimulus generator with halt-opcode drain monitor.
// Define IRQ_STIM_RR_EN to replace fixed lowest-index priority with round-robin arbitration.
module irq_stim_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 3,
    parameter int LFSR_WIDTH   = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1,
    parameter int PMD_SIZE     = 32,
    parameter int OP_MSB       = 31,
    parameter int OP_LSB       = 22,
    parameter logic [OP_MSB-OP_LSB:0] HALT_OPCODE = 10'd1,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_idle,
    input  logic [PMD_SIZE-1:0] pm_ps_op,
    input  logic [NUM_CH-1:0]   ch_enable,
    output logic [NUM_CH-1:0]   interrupt,
    output logic [2:0]          irq_id,
    output logic [15:0]         irq_count,
    output logic                halt_seen,
    output logic                sim_done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic logic [31:0] taps_for(input int width);
        case (width)
            3:       taps_for = 32'h0000_0006;
            4:       taps_for = 32'h0000_000C;
            5:       taps_for = 32'h0000_0014;
            6:       taps_for = 32'h0000_0030;
            7:       taps_for = 32'h0000_0060;
            8:       taps_for = 32'h0000_00B8;
            16:      taps_for = 32'h0000_B400;
            24:      taps_for = 32'h00E1_0000;
            32:      taps_for = 32'h8020_0003;
            default: taps_for = 32'h1 << (width - 1);
        endcase
    endfunction

    localparam logic [31:0]           TAPS32 = taps_for(LFSR_WIDTH);
    localparam logic [LFSR_WIDTH-1:0] TAPS   = TAPS32[LFSR_WIDTH-1:0];
    localparam logic [7:0]            DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    logic [LFSR_WIDTH-1:0] lfsr_reg;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [CNT_WIDTH-1:0]  cnt_reg [NUM_CH];
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     grant;
    logic [IDX_W-1:0]      winner;
    logic                  found;
    logic [7:0]            drain_reg;
    logic                  halt_match;
    logic                  unused_op_bits;

    assign halt_match     = (pm_ps_op[OP_MSB:OP_LSB] == HALT_OPCODE);
    assign unused_op_bits = ^pm_ps_op;

    // Right-shifting Galois form: feedback taps are XORed in when the bit shifted out is 1.
    assign lfsr_next = {1'b0, lfsr_reg[LFSR_WIDTH-1:1]} ^ (lfsr_reg[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign eligible[gi] = ps_idle && ch_enable[gi] && (cnt_reg[gi] == '0) && !halt_seen;
        end
    endgenerate

`ifdef IRQ_STIM_RR_EN
    logic [IDX_W-1:0] rr_reg;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(rr_reg) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_reg <= '0;
        end else if (found) begin
            rr_reg <= (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end
`endif

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign grant[gi] = found && (winner == IDX_W'(gi));

            // Counters only move while idle; a winner reloads from the pre-advance LFSR slice.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (ps_idle) begin
                    if (grant[gi]) begin
                        cnt_reg[gi] <= lfsr_reg[gi*CNT_WIDTH +: CNT_WIDTH];
                    end else if (cnt_reg[gi] != '0) begin
                        cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt <= '0;
            irq_id    <= '0;
            irq_count <= '0;
        end else begin
            interrupt <= grant;
            if (found) begin
                irq_id    <= 3'(winner);
                irq_count <= irq_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_seen <= 1'b0;
            sim_done  <= 1'b0;
            drain_reg <= '0;
        end else if (!halt_seen) begin
            if (halt_match) begin
                halt_seen <= 1'b1;
                drain_reg <= '0;
            end
        end else if (!sim_done) begin
            if (drain_reg == DRAIN_LAST) begin
                sim_done <= 1'b1;
            end else begin
                drain_reg <= drain_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_irq_stim_gen.sv
// Directed-vector bench for irq_stim_gen; expected values are hand-derived from the
// seed 16'hACE1 LFSR sequence (ACE1, E270, 7138, 389C, 1C4E, 0E27, ...).
module tb_irq_stim_gen;

    localparam logic [31:0] OP_HALT = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_idle;
    logic [31:0] pm_ps_op;
    logic [3:0]  ch_enable;
    logic [3:0]  interrupt;
    logic [2:0]  irq_id;
    logic [15:0] irq_count;
    logic        halt_seen;
    logic        sim_done;

    irq_stim_gen dut (
        .clk       (clk),
        .reset     (reset),
        .ps_idle   (ps_idle),
        .pm_ps_op  (pm_ps_op),
        .ch_enable (ch_enable),
        .interrupt (interrupt),
        .irq_id    (irq_id),
        .irq_count (irq_count),
        .halt_seen (halt_seen),
        .sim_done  (sim_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          idle;
        logic [3:0]  en;
        logic [31:0] op;
        logic [3:0]  x_int;
        logic [2:0]  x_id;
        logic [15:0] x_cnt;
        bit          x_halt;
        bit          x_done;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(bit rst, bit idle, logic [3:0] en, logic [31:0] op,
                                logic [3:0] xi, logic [2:0] xid, logic [15:0] xc,
                                bit xh, bit xd);
        vec_t v;
        v.rst = rst; v.idle = idle; v.en = en; v.op = op;
        v.x_int = xi; v.x_id = xid; v.x_cnt = xc; v.x_halt = xh; v.x_done = xd;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(int i);
        vec_t v;
        v = vecs[i];
        if (v.rst) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
        end
        ps_idle   = v.idle;
        ch_enable = v.en;
        pm_ps_op  = v.op;
        tick();
        $display("vec %0d: int=%b id=%0d cnt=%0d halt=%b done=%b",
                 i, interrupt, irq_id, irq_count, halt_seen, sim_done);
        check($sformatf("v%0d interrupt", i), 32'(interrupt), 32'(v.x_int));
        check($sformatf("v%0d irq_id", i),    32'(irq_id),    32'(v.x_id));
        check($sformatf("v%0d irq_count", i), 32'(irq_count), 32'(v.x_cnt));
        check($sformatf("v%0d halt_seen", i), 32'(halt_seen), 32'(v.x_halt));
        check($sformatf("v%0d sim_done", i),  32'(sim_done),  32'(v.x_done));
    endtask

    initial begin
        int n;

        // Single channel: reload 1, then 0 (back-to-back), then 4.
        add(1, 1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 2, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 3, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 4'b0001, 0, 4'b0000, 0, 3, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 4, 0, 0);

        // All channels enabled from reset; non-halt opcodes mixed in.
`ifdef IRQ_STIM_RR_EN
        add(1, 1, 4'b1111, 32'h0000_0000, 4'b0001, 0, 1, 0, 0);
        add(0, 1, 4'b1111, 32'h0080_0000, 4'b0010, 1, 2, 0, 0);
        add(0, 1, 4'b1111, 32'hFFC0_0000, 4'b0100, 2, 3, 0, 0);
        add(0, 1, 4'b1111, 32'h003F_FFFF, 4'b1000, 3, 4, 0, 0);
        add(0, 1, 4'b1111, 32'h0000_0000, 4'b0001, 0, 5, 0, 0);
        add(0, 1, 4'b1111, 32'h0000_0000, 4'b0000, 0, 5, 0, 0);
`else
        add(1, 1, 4'b1111, 32'h0000_0000, 4'b0001, 0, 1, 0, 0);
        add(0, 1, 4'b1111, 32'h0080_0000, 4'b0010, 1, 2, 0, 0);
        add(0, 1, 4'b1111, 32'hFFC0_0000, 4'b0001, 0, 3, 0, 0);
        add(0, 1, 4'b1111, 32'h003F_FFFF, 4'b0001, 0, 4, 0, 0);
        add(0, 1, 4'b1111, 32'h0000_0000, 4'b0100, 2, 5, 0, 0);
        add(0, 1, 4'b1111, 32'h0000_0000, 4'b1000, 3, 6, 0, 0);
`endif

        // Busy period freezes counters (ch0 holds 4) and blocks idle-eligible channels.
        add(1, 1, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0000, 0, 1, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 2, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 3, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 4'b1111, 0, 4'b0000, 0, 3, 0, 0);
        for (int k = 0; k < 4; k++)  add(0, 1, 4'b0001, 0, 4'b0000, 0, 3, 0, 0);
        add(0, 1, 4'b0001, 0, 4'b0001, 0, 4, 0, 0);

        // Halt coincides with an eligible channel; drain of 5 edges; repeat halt ignored.
        add(1, 1, 4'b0001, OP_HALT,         4'b0001, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 4'b1111, 0, 4'b0000, 0, 1, 1, 0);
        add(0, 1, 4'b1111, 32'h0000_0000,   4'b0000, 0, 1, 1, 1);
        add(0, 1, 4'b1111, 32'h0040_0123,   4'b0000, 0, 1, 1, 1);

        // Channels 0 and 2 contend on the fourth edge.
        add(1, 1, 4'b0101, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 1, 4'b0101, 0, 4'b0100, 2, 2, 0, 0);
        add(0, 1, 4'b0101, 0, 4'b0001, 0, 3, 0, 0);
`ifdef IRQ_STIM_RR_EN
        add(0, 1, 4'b0101, 0, 4'b0100, 2, 4, 0, 0);
`else
        add(0, 1, 4'b0101, 0, 4'b0001, 0, 4, 0, 0);
`endif

        reset     = 1'b1;
        ps_idle   = 1'b0;
        ch_enable = 4'b0000;
        pm_ps_op  = 32'h0;
        #3;
        check("rst interrupt", 32'(interrupt), 32'h0);
        check("rst irq_id",    32'(irq_id),    32'h0);
        check("rst irq_count", 32'(irq_count), 32'h0);
        check("rst halt_seen", 32'(halt_seen), 32'h0);
        check("rst sim_done",  32'(sim_done),  32'h0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Asynchronous reset mid-drain, then a fresh full-length drain.
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        ps_idle   = 1'b1;
        ch_enable = 4'b0001;
        pm_ps_op  = OP_HALT;
        tick();
        check("mid halt_seen", 32'(halt_seen), 32'h1);
        check("mid irq_count", 32'(irq_count), 32'h1);
        ps_idle   = 1'b0;
        ch_enable = 4'b0000;
        pm_ps_op  = 32'h0;
        tick();
        tick();
        tick();
        check("mid sim_done", 32'(sim_done), 32'h0);
        reset = 1'b1;
        #1;
        check("async halt_seen", 32'(halt_seen), 32'h0);
        check("async sim_done",  32'(sim_done),  32'h0);
        check("async irq_count", 32'(irq_count), 32'h0);
        #1;
        reset    = 1'b0;
        pm_ps_op = OP_HALT;
        tick();
        check("rehalt halt_seen", 32'(halt_seen), 32'h1);
        pm_ps_op = 32'h0;
        n = 0;
        while (sim_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        $display("redrain: sim_done after %0d edges", n);
        check("redrain edges", 32'(n), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
